// File: rtl/mul_div_unit_pkg.sv
// Shared definitions for the multiply/divide unit: operation codes, FSM states
// and small helpers used by both the control block and the arithmetic block.
// Imported by mul_div_unit and mdu_calc; no ports.
package mul_div_unit_pkg;

    // Operation codes driven on mdOp by the decoder.
    typedef enum logic [2:0] {
        MDU_NONE  = 3'd0,
        MDU_MULT  = 3'd1,
        MDU_MULTU = 3'd2,
        MDU_DIV   = 3'd3,
        MDU_DIVU  = 3'd4,
        MDU_MTHI  = 3'd5,
        MDU_MTLO  = 3'd6
    } mdu_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mdu_state_e;

    function automatic logic is_mul(input logic [2:0] op);
        return (op == MDU_MULT) || (op == MDU_MULTU);
    endfunction

    function automatic logic is_div(input logic [2:0] op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/mdu_calc.sv
// Combinational multiply/divide datapath: latched op + operands -> HI/LO candidates.
// Ports: i_op (operation), i_a/i_b (operands), o_hi/o_lo (results), o_div_by_zero.
// Pure combinational, zero latency; the owning FSM decides when to commit.
module mdu_calc
    import mul_div_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo,
    output logic             o_div_by_zero
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [2*WIDTH-1:0] w_sprod;
    logic [2*WIDTH-1:0] w_uprod;
    logic               w_sdiv;
    logic               w_neg_a;
    logic               w_neg_b;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic [WIDTH-1:0]   w_divisor;
    logic [WIDTH-1:0]   w_q_mag;
    logic [WIDTH-1:0]   w_r_mag;
    logic [WIDTH-1:0]   w_quot;
    logic [WIDTH-1:0]   w_rem;

    // Explicit sign/zero extension to 2*WIDTH: the low 2*WIDTH bits of the
    // extended product equal the signed (resp. unsigned) full product.
    assign w_sprod = {{WIDTH{i_a[WIDTH-1]}}, i_a} * {{WIDTH{i_b[WIDTH-1]}}, i_b};
    assign w_uprod = {{WIDTH{1'b0}}, i_a} * {{WIDTH{1'b0}}, i_b};

    // Signed division runs as unsigned division on magnitudes. MIN_INT / -1
    // falls out naturally: |MIN_INT| = 2^(WIDTH-1) unsigned, negated back to
    // MIN_INT, remainder 0.
    assign w_sdiv    = (i_op == MDU_DIV);
    assign w_neg_a   = w_sdiv & i_a[WIDTH-1];
    assign w_neg_b   = w_sdiv & i_b[WIDTH-1];
    assign w_mag_a   = w_neg_a ? -i_a : i_a;
    assign w_mag_b   = w_neg_b ? -i_b : i_b;
    // Substitute a divisor of 1 when zero so the divider never sees /0;
    // the result is discarded via o_div_by_zero anyway.
    assign w_divisor = (i_b == '0) ? ONE : w_mag_b;
    assign w_q_mag   = w_mag_a / w_divisor;
    assign w_r_mag   = w_mag_a % w_divisor;
    // Quotient truncates toward zero; remainder follows the dividend sign.
    assign w_quot    = (w_neg_a ^ w_neg_b) ? -w_q_mag : w_q_mag;
    assign w_rem     = w_neg_a ? -w_r_mag : w_r_mag;

    assign o_div_by_zero = is_div(i_op) && (i_b == '0);

    always_comb begin
        o_hi = '0;
        o_lo = '0;
        case (i_op)
            MDU_MULT:           {o_hi, o_lo} = w_sprod;
            MDU_MULTU:          {o_hi, o_lo} = w_uprod;
            MDU_DIV, MDU_DIVU: begin
                o_hi = w_rem;
                o_lo = w_quot;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mul_div_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers (EX-stage ALU companion).
// Ports: clk, reset, start/mdOp/srcA/srcB (launch), busy, hi, lo.
// Latency MUL_CYCLES / DIV_CYCLES; mthi/mtlo take one edge; start while busy is ignored.
module mul_div_unit
    import mul_div_unit_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       mdOp,
    input  logic [WIDTH-1:0] srcA,
    input  logic [WIDTH-1:0] srcB,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int               MAX_CYCLES = max_int(MUL_CYCLES, DIV_CYCLES);
    localparam int               CNT_W      = $clog2(MAX_CYCLES + 1);
    localparam logic [CNT_W-1:0] MUL_CNT    = CNT_W'(MUL_CYCLES);
    localparam logic [CNT_W-1:0] DIV_CNT    = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    mdu_state_e       r_state;
    mdu_state_e       w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;

    logic             w_idle_start;
    logic             w_load;
    logic             w_done;
    logic [WIDTH-1:0] w_hi_next;
    logic [WIDTH-1:0] w_lo_next;
    logic             w_div_by_zero;

    // Arithmetic works only from latched operands so srcA/srcB may move on.
    mdu_calc #(
        .WIDTH (WIDTH)
    ) u_calc (
        .i_op          (r_op),
        .i_a           (r_a),
        .i_b           (r_b),
        .o_hi          (w_hi_next),
        .o_lo          (w_lo_next),
        .o_div_by_zero (w_div_by_zero)
    );

    assign w_idle_start = (r_state == ST_IDLE) && start;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start && (is_mul(mdOp) || is_div(mdOp))) begin
                    w_state_next = ST_BUSY;
                    w_load       = 1'b1;
                end
            end
            ST_BUSY: begin
                if (r_cnt == CNT_ONE) begin
                    w_state_next = ST_IDLE;
                    w_done       = 1'b1;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Operand latch and cycle counter; counter reaches 0 on the completing edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
            r_op  <= MDU_NONE;
            r_a   <= '0;
            r_b   <= '0;
        end else if (w_load) begin
            r_cnt <= is_mul(mdOp) ? MUL_CNT : DIV_CNT;
            r_op  <= mdOp;
            r_a   <= srcA;
            r_b   <= srcB;
        end else if (r_state == ST_BUSY) begin
            r_cnt <= r_cnt - CNT_ONE;
        end
    end

    // HI/LO only change on an idle mthi/mtlo or on the completing edge;
    // a zero divisor completes without touching either register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (w_idle_start && (mdOp == MDU_MTHI)) begin
            r_hi <= srcA;
        end else if (w_idle_start && (mdOp == MDU_MTLO)) begin
            r_lo <= srcA;
        end else if (w_done && !w_div_by_zero) begin
            r_hi <= w_hi_next;
            r_lo <= w_lo_next;
        end
    end

    assign busy = (r_state == ST_BUSY);
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule
